mem_port_arbiter: RTL and testbench

- Shares one single-ported, multi-cycle backing memory between two requesters: the instruction-fetch stage and the memory stage (LD/ST/STU accesses decoded as MemRead/MemWrt).
- Sequences each access with a request/done handshake, with one access outstanding at a time.
- Drives the stall signals that freeze the pipeline while an access is pending.
- Handles fetch flush on taken branches or jumps, and flags protocol and timeout errors.

---
 rtl/mips_mem_pkg.sv | 15 +
 rtl/mem_port_arbiter_timeout_cnt.sv | 33 +++
 rtl/mem_port_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and sizing constants for the instruction/data memory port arbiter.
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int TMO_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        DRAIN  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Watchdog for a held backend strobe: expire is high during the TIMEOUT-th enabled cycle.
module arb_timeout_cnt
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT = 15
)(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(TIMEOUT - 1);
            logic [TMO_CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    cnt_reg <= '0;
                end else if (en) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign expire = en && (cnt_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter for one multi-cycle backing memory.
// Optional odd-address trapping is enabled by defining MEM_ALIGN_CHK_EN.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              flush,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              err
);

    arb_state_t        state_reg, state_next;
    logic              mem_en_reg, mem_en_next;
    logic              mem_wr_reg, mem_wr_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
    logic [DATA_W-1:0] dm_rdata_reg, dm_rdata_next;
    logic              if_done_reg, if_done_next;
    logic              dm_done_reg, dm_done_next;
    logic              err_reg, err_next;
    logic              expire;
    logic              done_blank;
    logic              dm_misalign;
    logic              if_misalign;

    arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (~mem_en_reg),
        .en     (mem_en_reg),
        .expire (expire)
    );

`ifdef MEM_ALIGN_CHK_EN
    assign dm_misalign = dm_addr[0];
    assign if_misalign = if_addr[0];
`else
    assign dm_misalign = 1'b0;
    assign if_misalign = 1'b0;
`endif

    // Requesters still hold their request during their done cycle; granting then would repeat it.
    assign done_blank = if_done_reg | dm_done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            mem_en_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_rdata_reg  <= '0;
            dm_rdata_reg  <= '0;
            if_done_reg   <= 1'b0;
            dm_done_reg   <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mem_en_reg    <= mem_en_next;
            mem_wr_reg    <= mem_wr_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            if_rdata_reg  <= if_rdata_next;
            dm_rdata_reg  <= dm_rdata_next;
            if_done_reg   <= if_done_next;
            dm_done_reg   <= dm_done_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mem_en_next    = mem_en_reg;
        mem_wr_next    = mem_wr_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        if_rdata_next  = if_rdata_reg;
        dm_rdata_next  = dm_rdata_reg;
        if_done_next   = 1'b0;
        dm_done_next   = 1'b0;
        err_next       = err_reg;

        case (state_reg)
            IDLE: begin
                if (mem_done) begin
                    err_next = 1'b1;
                end
                if (!done_blank) begin
                    if (dm_rd && dm_wr) begin
                        err_next     = 1'b1;
                        dm_done_next = 1'b1;
                    end else if (dm_rd || dm_wr) begin
                        if (dm_misalign) begin
                            err_next      = 1'b1;
                            dm_done_next  = 1'b1;
                            dm_rdata_next = '0;
                        end else begin
                            mem_en_next    = 1'b1;
                            mem_wr_next    = dm_wr;
                            mem_addr_next  = dm_addr;
                            mem_wdata_next = dm_wdata;
                            state_next     = BUSY_D;
                        end
                    end else if (if_req && !flush) begin
                        if (if_misalign) begin
                            err_next      = 1'b1;
                            if_done_next  = 1'b1;
                            if_rdata_next = '0;
                        end else begin
                            mem_en_next   = 1'b1;
                            mem_wr_next   = 1'b0;
                            mem_addr_next = if_addr;
                            state_next    = BUSY_I;
                        end
                    end
                end
            end

            BUSY_D: begin
                if (mem_done) begin
                    if (!mem_wr_reg) begin
                        dm_rdata_next = mem_rdata;
                    end
                    dm_done_next = 1'b1;
                    mem_en_next  = 1'b0;
                    state_next   = IDLE;
                end else if (expire) begin
                    err_next      = 1'b1;
                    dm_done_next  = 1'b1;
                    dm_rdata_next = '0;
                    mem_en_next   = 1'b0;
                    state_next    = IDLE;
                end
            end

            BUSY_I: begin
                // A flush coinciding with completion still discards the fetched word.
                if (mem_done) begin
                    if (!flush) begin
                        if_rdata_next = mem_rdata;
                        if_done_next  = 1'b1;
                    end
                    mem_en_next = 1'b0;
                    state_next  = IDLE;
                end else if (expire) begin
                    err_next    = 1'b1;
                    mem_en_next = 1'b0;
                    state_next  = IDLE;
                    if (!flush) begin
                        if_rdata_next = '0;
                        if_done_next  = 1'b1;
                    end
                end else if (flush) begin
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                if (mem_done || expire) begin
                    err_next    = err_reg | (expire & ~mem_done);
                    mem_en_next = 1'b0;
                    state_next  = IDLE;
                end
            end

            default: begin
                state_next  = IDLE;
                mem_en_next = 1'b0;
            end
        endcase
    end

    assign if_rdata  = if_rdata_reg;
    assign if_done   = if_done_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign dm_done   = dm_done_reg;
    assign mem_en    = mem_en_reg;
    assign mem_wr    = mem_wr_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign err       = err_reg;

    assign dm_stall = (dm_rd | dm_wr) & ~dm_done_reg;
    assign if_stall = (if_req & ~if_done_reg) | dm_stall;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: backend memory model, completion scoreboard,
// vector table plus hand-written timing, flush, error, timeout and reset sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        flush = 1'b0;
    logic        dm_rd = 1'b0;
    logic        dm_wr = 1'b0;
    logic [15:0] dm_addr = '0;
    logic [15:0] dm_wdata = '0;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        err;

    logic        be_done = 1'b0;
    logic [15:0] be_rdata = '0;
    logic        spur = 1'b0;
    logic        silent = 1'b0;
    int          lat = 3;
    int          bcnt = 0;
    logic [15:0] bmem [0:1023];
    bit          written [0:1023];

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          is_data;
        logic [15:0] rdata;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        int          kind;      // 0 fetch, 1 load, 2 store
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] exp_rdata;
    } vec_t;
    vec_t vt [8];

    assign mem_rdata = be_rdata;
    assign mem_done  = be_done | spur;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .flush     (flush),
        .dm_rd     (dm_rd),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .dm_stall  (dm_stall),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .err       (err)
    );

    function automatic logic [15:0] pat(input logic [15:0] a);
        return {a[7:0], ~a[7:0]} ^ 16'h1357;
    endfunction

    function automatic logic [15:0] be_read(input logic [15:0] a);
        return written[a[9:0]] ? bmem[a[9:0]] : pat(a);
    endfunction

    // Backend: answers lat cycles after it first sees mem_en.
    always @(posedge clk) begin
        if (rst) begin
            be_done <= 1'b0;
            bcnt    <= 0;
        end else if (be_done) begin
            be_done <= 1'b0;
            bcnt    <= 0;
        end else if (mem_en && !silent) begin
            if (bcnt + 1 >= lat) begin
                be_done  <= 1'b1;
                bcnt     <= 0;
                be_rdata <= be_read(mem_addr);
                if (mem_wr) begin
                    bmem[mem_addr[9:0]]    <= mem_wdata;
                    written[mem_addr[9:0]] <= 1'b1;
                end
            end else begin
                bcnt <= bcnt + 1;
            end
        end else begin
            bcnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (!rst && (if_done || dm_done)) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual if_done=%0b dm_done=%0b required none", if_done, dm_done);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("done_kind", {31'd0, dm_done}, {31'd0, e.is_data});
                chk("done_rdata", {16'd0, (dm_done ? dm_rdata : if_rdata)}, {16'd0, e.rdata});
                $display("txn %s done rdata=%h exp=%h", dm_done ? "data " : "fetch",
                         dm_done ? dm_rdata : if_rdata, e.rdata);
            end
        end
    end

    task automatic push(input bit is_data, input logic [15:0] rdata);
        sb_t e;
        e.is_data = is_data;
        e.rdata   = rdata;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0; flush = 1'b0; spur = 1'b0; silent = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sbq.delete();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_if_rdata"}, {16'd0, if_rdata}, 32'd0);
        chk({tag, "_if_done"}, {31'd0, if_done}, 32'd0);
        chk({tag, "_if_stall"}, {31'd0, if_stall}, 32'd0);
        chk({tag, "_dm_rdata"}, {16'd0, dm_rdata}, 32'd0);
        chk({tag, "_dm_done"}, {31'd0, dm_done}, 32'd0);
        chk({tag, "_dm_stall"}, {31'd0, dm_stall}, 32'd0);
        chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        chk({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
        chk({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic do_req(input int kind, input logic [15:0] addr, input logic [15:0] wdata,
                          input int l, input logic [15:0] exp_rdata);
        bit seen;
        @(negedge clk);
        lat = l;
        if (kind == 0) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            dm_rd = (kind == 1); dm_wr = (kind == 2); dm_addr = addr; dm_wdata = wdata;
        end
        push(kind != 0, exp_rdata);
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if ((kind == 0 && if_done) || (kind != 0 && dm_done)) begin
                seen = 1'b1;
                break;
            end
        end
        if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
        chk("req_completed", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        bit seen;
        int cnt;

        vt[0] = '{0, 16'h0010, 16'h0000, 3, pat(16'h0010)};
        vt[1] = '{1, 16'h0022, 16'h0000, 1, pat(16'h0022)};
        vt[2] = '{2, 16'h0100, 16'hBEEF, 2, pat(16'h0022)};
        vt[3] = '{1, 16'h0100, 16'h0000, 4, 16'hBEEF};
        vt[4] = '{0, 16'h0100, 16'h0000, 1, 16'hBEEF};
        vt[5] = '{2, 16'h0200, 16'h1234, 5, 16'hBEEF};
        vt[6] = '{0, 16'h0200, 16'h0000, 2, 16'h1234};
        vt[7] = '{1, 16'h03FE, 16'h0000, 1, pat(16'h03FE)};

        do_reset();
        @(negedge clk);
        check_idle("reset");

        // Fetch-only timing with a 3-cycle backend.
        @(negedge clk);
        lat = 3; if_req = 1'b1; if_addr = 16'h0010;
        push(1'b0, pat(16'h0010));
        #1 chk("a_stall_t0", {31'd0, if_stall}, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("a_mem_en", {31'd0, mem_en}, {31'd0, (k <= 4)});
            chk("a_if_done", {31'd0, if_done}, {31'd0, (k == 5)});
            chk("a_if_stall", {31'd0, if_stall}, {31'd0, (k <= 4)});
            if (k == 1) begin
                chk("a_mem_addr", {16'd0, mem_addr}, 32'h0010);
                chk("a_mem_wr", {31'd0, mem_wr}, 32'd0);
            end
            if (k == 5) if_req = 1'b0;
        end

        // Simultaneous store and fetch: data first.
        @(negedge clk);
        lat = 2;
        dm_wr = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF;
        if_req = 1'b1; if_addr = 16'h0040;
        push(1'b1, 16'h0000);
        push(1'b0, pat(16'h0040));
        #1 chk("b_dm_stall", {31'd0, dm_stall}, 32'd1);
        chk("b_if_stall", {31'd0, if_stall}, 32'd1);
        @(negedge clk);
        chk("b_mem_en", {31'd0, mem_en}, 32'd1);
        chk("b_mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("b_mem_addr", {16'd0, mem_addr}, 32'h0100);
        chk("b_mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (dm_done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        dm_wr = 1'b0;
        chk("b_dm_done_seen", {31'd0, seen}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (mem_en) begin seen = 1'b1; break; end
        end
        chk("b_fetch_granted", {31'd0, seen}, 32'd1);
        chk("b_fetch_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("b_fetch_addr", {16'd0, mem_addr}, 32'h0040);
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (if_done) begin seen = 1'b1; break; end
        end
        if_req = 1'b0;
        chk("b_if_done_seen", {31'd0, seen}, 32'd1);
        chk("b_backend_word", {16'd0, be_read(16'h0100)}, 32'hBEEF);

        // Flush during a fetch: drained, then the redirected fetch completes.
        @(negedge clk);
        lat = 6; if_req = 1'b1; if_addr = 16'h0030;
        @(negedge clk);
        chk("c_mem_en_t1", {31'd0, mem_en}, 32'd1);
        @(negedge clk);
        flush = 1'b1; if_addr = 16'h0040;
        push(1'b0, pat(16'h0040));
        @(negedge clk);
        flush = 1'b0;
        chk("c_drain_addr", {16'd0, mem_addr}, 32'h0030);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (!mem_en) break;
            cnt++;
            @(negedge clk);
        end
        chk("c_drain_cycles", cnt, 32'd5);
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (if_done) begin seen = 1'b1; break; end
        end
        if_req = 1'b0;
        chk("c_refetch_done", {31'd0, seen}, 32'd1);

        for (int v = 0; v < 8; v++) begin
            do_req(vt[v].kind, vt[v].addr, vt[v].wdata, vt[v].lat, vt[v].exp_rdata);
        end

        // Protocol error: read and write together.
        chk("d_err_before", {31'd0, err}, 32'd0);
        @(negedge clk);
        dm_rd = 1'b1; dm_wr = 1'b1;
        push(1'b1, pat(16'h03FE));
        @(negedge clk);
        chk("d_err", {31'd0, err}, 32'd1);
        chk("d_dm_done", {31'd0, dm_done}, 32'd1);
        chk("d_no_mem_en", {31'd0, mem_en}, 32'd0);
        dm_rd = 1'b0; dm_wr = 1'b0;
        repeat (3) @(negedge clk);
        chk("d_err_sticky", {31'd0, err}, 32'd1);
        chk("d_mem_en_idle", {31'd0, mem_en}, 32'd0);
        do_req(1, 16'h0022, 16'h0000, 1, pat(16'h0022));
        chk("d_err_still", {31'd0, err}, 32'd1);
        do_reset();
        @(negedge clk);
        check_idle("d_rst");

        // Stray mem_done while idle.
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("g_spur_err", {31'd0, err}, 32'd1);
        do_reset();

        // Timeout with a silent backend.
        do_req(1, 16'h0022, 16'h0000, 1, pat(16'h0022));
        @(negedge clk);
        silent = 1'b1; dm_rd = 1'b1; dm_addr = 16'h0050;
        push(1'b1, 16'h0000);
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_en) cnt++;
            if (dm_done) begin seen = 1'b1; break; end
        end
        dm_rd = 1'b0; silent = 1'b0;
        chk("e_done_seen", {31'd0, seen}, 32'd1);
        chk("e_mem_en_cycles", cnt, 32'd15);
        chk("e_err", {31'd0, err}, 32'd1);
        chk("e_mem_en_low", {31'd0, mem_en}, 32'd0);

        // Reset in the middle of an access clears everything, including err.
        do_req(0, 16'h0010, 16'h0000, 1, pat(16'h0010));
        @(negedge clk);
        lat = 10; if_req = 1'b1; if_addr = 16'h0060;
        repeat (3) @(negedge clk);
        chk("f_mem_en_before", {31'd0, mem_en}, 32'd1);
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        check_idle("f_rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("f_stays_idle", {31'd0, mem_en}, 32'd0);

        chk("sb_empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

endmodule
